// File: rtl/op_data_pkg.sv
// Shared encodings and default code-field positions for the op_data unit.
package op_data_pkg;

    typedef enum logic [1:0] {
        DATA_NOP = 2'd0,
        DATA_MOD = 2'd1,
        DATA_SET = 2'd2,
        DATA_GET = 2'd3
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    localparam int F_PN_BIT  = 15;
    localparam int F_MEM_BIT = 13;
    localparam int IMM_LSB   = 4;

endpackage

// File: rtl/op_data_alu.sv
// Combinational result/flag generation for MOD/SET/GET.
// Optional clamping of MOD results is enabled by OP_DATA_SATURATE_EN.
module op_data_alu
    import op_data_pkg::*;
#(
    parameter int DATA_BITWIDTH = 8,
    parameter int CODE_BITWIDTH = 16,
    parameter int IMM_LSB       = op_data_pkg::IMM_LSB,
    parameter int IMM_BITWIDTH  = 8,
    parameter int F_PN_BIT      = op_data_pkg::F_PN_BIT,
    parameter int F_MEM_BIT     = op_data_pkg::F_MEM_BIT
) (
    input  op_e                      op,
    input  logic [CODE_BITWIDTH-1:0] code,
    input  logic [DATA_BITWIDTH-1:0] data,
    input  logic [DATA_BITWIDTH-1:0] in,
    output logic [DATA_BITWIDTH-1:0] res,
    output logic                     carry,
    output logic                     zero
);

    logic [IMM_BITWIDTH-1:0]  imm_raw;
    logic [DATA_BITWIDTH-1:0] imm;
    logic [DATA_BITWIDTH:0]   sum;
    logic [DATA_BITWIDTH-1:0] diff;
    logic                     unused_code;

    assign imm_raw     = code[IMM_LSB +: IMM_BITWIDTH];
    assign unused_code = ^code;

    generate
        if (IMM_BITWIDTH >= DATA_BITWIDTH) begin : g_imm_trunc
            assign imm = imm_raw[DATA_BITWIDTH-1:0];
        end else begin : g_imm_zext
            assign imm = {{(DATA_BITWIDTH-IMM_BITWIDTH){1'b0}}, imm_raw};
        end
    endgenerate

    assign sum  = {1'b0, data} + {1'b0, imm};
    assign diff = data - imm;

    // NOTE: outputs get defaults before the case so no path leaves them unassigned (no latches).
    always_comb begin
        res   = '0;
        carry = 1'b0;
        case (op)
            DATA_MOD: begin
                if (code[F_PN_BIT]) begin
                    res   = diff;
                    carry = (data < imm);
`ifdef OP_DATA_SATURATE_EN
                    if (carry) res = '0;
`endif
                end else begin
                    {carry, res} = sum;
`ifdef OP_DATA_SATURATE_EN
                    if (carry) res = '1;
`endif
                end
            end
            DATA_SET: res = code[F_MEM_BIT] ? data : imm;
            DATA_GET: res = in;
            default:  res = data;
        endcase
        zero = (res == '0);
    end

endmodule

// File: rtl/op_data_unit.sv
// Data-operation stage: op handshake, result/flag registers and acknowledged write-back.
// Build option OP_DATA_SATURATE_EN selects clamping MOD arithmetic in op_data_alu.
module op_data_unit
    import op_data_pkg::*;
#(
    parameter int DATA_BITWIDTH = 8,
    parameter int CODE_BITWIDTH = 16,
    parameter int IMM_LSB       = op_data_pkg::IMM_LSB,
    parameter int IMM_BITWIDTH  = 8,
    parameter int F_PN_BIT      = op_data_pkg::F_PN_BIT,
    parameter int F_MEM_BIT     = op_data_pkg::F_MEM_BIT,
    parameter int WR_TIMEOUT    = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [1:0]               flag_op_data,
    input  logic                     flag_op_data_wr,
    input  logic [CODE_BITWIDTH-1:0] code,
    input  logic [DATA_BITWIDTH-1:0] data,
    input  logic [DATA_BITWIDTH-1:0] in,
    output logic [DATA_BITWIDTH-1:0] data_out,
    output logic                     data_wr,
    input  logic                     data_wr_ack,
    output logic                     flag_zero,
    output logic                     flag_carry,
    output logic                     err_timeout,
    input  logic                     err_clr
);

    localparam int CNT_W = $clog2(WR_TIMEOUT + 1);

    state_e                   state, state_d;
    logic [CNT_W-1:0]         wr_cnt;
    logic [DATA_BITWIDTH-1:0] alu_res;
    logic                     alu_carry;
    logic                     alu_zero;
    logic                     accept;
    logic                     timeout_hit;

    op_data_alu #(
        .DATA_BITWIDTH (DATA_BITWIDTH),
        .CODE_BITWIDTH (CODE_BITWIDTH),
        .IMM_LSB       (IMM_LSB),
        .IMM_BITWIDTH  (IMM_BITWIDTH),
        .F_PN_BIT      (F_PN_BIT),
        .F_MEM_BIT     (F_MEM_BIT)
    ) u_alu (
        .op    (op_e'(flag_op_data)),
        .code  (code),
        .data  (data),
        .in    (in),
        .res   (alu_res),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    assign op_ready = (state == IDLE);
    assign accept   = op_valid & op_ready;
    // Last cycle of the write window; an ack on the same edge takes priority.
    assign timeout_hit = (state == WRITE) & ~data_wr_ack &
                         (wr_cnt == CNT_W'(WR_TIMEOUT - 1));

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept && flag_op_data_wr) state_d = WRITE;
            WRITE:   if (data_wr_ack || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            data_out    <= '0;
            data_wr     <= 1'b0;
            flag_zero   <= 1'b1;
            flag_carry  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state   <= state_d;
            data_wr <= (state_d == WRITE);

            if (accept && (op_e'(flag_op_data) != DATA_NOP)) begin
                data_out   <= alu_res;
                flag_zero  <= alu_zero;
                flag_carry <= alu_carry;
            end

            if (state == WRITE && !data_wr_ack) wr_cnt <= wr_cnt + CNT_W'(1);
            else                                wr_cnt <= '0;

            if (timeout_hit)  err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_op_data_unit.sv
// Self-checking bench for op_data_unit: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_op_data_unit;

    localparam int TB_TO = 4;
`ifdef OP_DATA_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  flag_op_data = 2'd0;
    logic        flag_op_data_wr = 1'b0;
    logic [15:0] code = '0;
    logic [7:0]  data = '0;
    logic [7:0]  in_v = '0;
    logic [7:0]  data_out;
    logic        data_wr;
    logic        data_wr_ack = 1'b0;
    logic        flag_zero;
    logic        flag_carry;
    logic        err_timeout;
    logic        err_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    op_data_unit #(.WR_TIMEOUT(TB_TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .flag_op_data    (flag_op_data),
        .flag_op_data_wr (flag_op_data_wr),
        .code            (code),
        .data            (data),
        .in              (in_v),
        .data_out        (data_out),
        .data_wr         (data_wr),
        .data_wr_ack     (data_wr_ack),
        .flag_zero       (flag_zero),
        .flag_carry      (flag_carry),
        .err_timeout     (err_timeout),
        .err_clr         (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: transaction-level view of results, busy window and error flag.
    int m_out = 0, m_zero = 1, m_carry = 0, m_err = 0, m_busy = 0, m_wait = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out = 0; m_zero = 1; m_carry = 0; m_err = 0; m_busy = 0; m_wait = 0;
        end else if (m_busy == 0) begin
            if (op_valid) begin
                if (flag_op_data != 2'd0) begin
                    int d, im, r, c;
                    d  = int'(data);
                    im = int'(code[11:4]);
                    c  = 0;
                    case (flag_op_data)
                        2'd1: begin
                            if (code[15]) begin
                                r = d - im;
                                if (r < 0) begin c = 1; r = SAT ? 0 : r + 256; end
                            end else begin
                                r = d + im;
                                if (r > 255) begin c = 1; r = SAT ? 255 : r - 256; end
                            end
                        end
                        2'd2:    r = code[13] ? d : im;
                        default: r = int'(in_v);
                    endcase
                    m_out = r; m_carry = c; m_zero = (r == 0) ? 1 : 0;
                end
                if (flag_op_data_wr) begin m_busy = 1; m_wait = 0; end
            end
            if (err_clr) m_err = 0;
        end else begin
            m_wait++;
            if (err_clr) m_err = 0;
            if (data_wr_ack) m_busy = 0;
            else if (m_wait == TB_TO) begin m_busy = 0; m_err = 1; end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_data_out", data_out, m_out);
            check("m_zero", flag_zero, m_zero);
            check("m_carry", flag_carry, m_carry);
            check("m_err", err_timeout, m_err);
            check("m_data_wr", data_wr, m_busy);
            check("m_op_ready", op_ready, (m_busy == 0));
        end
    end

    function automatic logic [15:0] mk(input logic [7:0] imm, input logic pn, input logic mem);
        return {pn, 1'b0, mem, 1'b0, imm, 4'h0};
    endfunction

    task automatic step(input logic v, input logic [1:0] op, input logic wr, input logic [15:0] c,
                        input logic [7:0] d, input logic [7:0] i, input logic ack, input logic clr);
        op_valid = v; flag_op_data = op; flag_op_data_wr = wr; code = c;
        data = d; in_v = i; data_wr_ack = ack; err_clr = clr;
        @(negedge clk);
    endtask

    task automatic idle_step(input logic ack, input logic clr);
        step(1'b0, 2'd0, 1'b0, 16'h0, 8'h0, 8'h0, ack, clr);
    endtask

    initial begin
        int hi;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("rst_data_out", data_out, 0);
        check("rst_zero", flag_zero, 1);
        check("rst_data_wr", data_wr, 0);
        check("rst_ready", op_ready, 1);
        rst_n = 1'b1;
        idle_step(0, 0);

        // add with carry, next op accepted immediately
        step(1, 2'd1, 0, mk(8'h20, 0, 0), 8'hF0, 0, 0, 0);
        check("add_out", data_out, SAT ? 8'hFF : 8'h10);
        check("add_carry", flag_carry, 1);
        check("add_zero", flag_zero, 0);
        check("add_ready", op_ready, 1);

        step(1, 2'd1, 0, mk(8'h05, 1, 0), 8'h05, 0, 0, 0);
        check("sub_eq_out", data_out, 0);
        check("sub_eq_zero", flag_zero, 1);
        check("sub_eq_carry", flag_carry, 0);

        step(1, 2'd1, 0, mk(8'h05, 1, 0), 8'h03, 0, 0, 0);
        check("sub_bor_out", data_out, SAT ? 8'h00 : 8'hFE);
        check("sub_bor_carry", flag_carry, 1);
        check("sub_bor_zero", flag_zero, SAT ? 1 : 0);

        // SET imm with write-back, ack on the fourth write cycle; a GET is held off meanwhile
        step(1, 2'd2, 1, mk(8'h5A, 0, 0), 8'h11, 0, 0, 0);
        hi = 0;
        for (int k = 0; k < 4; k++) begin
            check("set_ready_low", op_ready, 0);
            if (data_wr) hi++;
            step(1, 2'd3, 0, 16'h0, 0, 8'h77, (k == 3), 0);
        end
        check("set_wr_cycles", hi, 4);
        check("set_wr_done", data_wr, 0);
        check("set_out", data_out, 8'h5A);
        check("set_err", err_timeout, 0);
        check("set_ready", op_ready, 1);

        // write timeout, sticky error, clear
        step(1, 2'd3, 1, 16'h0, 0, 8'h33, 0, 0);
        hi = 0;
        while (data_wr && hi < 20) begin hi++; idle_step(0, 0); end
        check("to_cycles", hi, TB_TO);
        check("to_err", err_timeout, 1);
        check("to_out", data_out, 8'h33);
        idle_step(0, 0); idle_step(1, 0);
        check("to_sticky", err_timeout, 1);
        idle_step(0, 1);
        check("to_clr", err_timeout, 0);

        // ack on the timeout edge: no error
        step(1, 2'd3, 1, 16'h0, 0, 8'h34, 0, 0);
        for (int k = 0; k < TB_TO; k++) idle_step(k == TB_TO - 1, 0);
        check("ack_edge_err", err_timeout, 0);
        check("ack_edge_wr", data_wr, 0);

        // timeout with err_clr held: set wins
        step(1, 2'd3, 1, 16'h0, 0, 8'h35, 0, 1);
        for (int k = 0; k < TB_TO; k++) idle_step(0, 1);
        check("to_clr_set_wins", err_timeout, 1);
        idle_step(0, 1);
        check("to_clr_after", err_timeout, 0);

        // back-to-back GET, SET_MEM, NOP, MOD
        step(1, 2'd3, 0, 16'h0, 0, 8'h44, 0, 0);
        check("b2b_get", data_out, 8'h44);
        step(1, 2'd2, 0, mk(8'h12, 0, 1), 8'h00, 0, 0, 0);
        check("b2b_setmem", data_out, 8'h00);
        check("b2b_setmem_zero", flag_zero, 1);
        step(1, 2'd0, 0, mk(8'hFF, 0, 0), 8'h99, 8'h99, 0, 0);
        check("b2b_nop_out", data_out, 8'h00);
        check("b2b_nop_zero", flag_zero, 1);
        step(1, 2'd1, 0, mk(8'h02, 0, 0), 8'h01, 0, 0, 0);
        check("b2b_mod", data_out, 8'h03);
        check("b2b_mod_zero", flag_zero, 0);

        // asynchronous reset in the middle of a write
        step(1, 2'd2, 1, mk(8'hC3, 0, 0), 0, 0, 0, 0);
        idle_step(0, 0);
        check("mid_wr_high", data_wr, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr", data_wr, 0);
        check("mid_rst_out", data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_step(0, 0);
        check("mid_rst_ready", op_ready, 1);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 3,
                 16'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 7) == 0);
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
